// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state codes, image framing constants and a small image-size helper.
package imem_boot_pkg;

   // Image framing: a 2-byte little-endian word count, then 4 bytes per word.
   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   // Loader states (plain constants so older tools and netlists see fixed codes).
   localparam logic [2:0] HDR_LO = 3'd0;
   localparam logic [2:0] HDR_HI = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] CHECK  = 3'd3;
   localparam logic [2:0] RUN    = 3'd4;
   localparam logic [2:0] ERR    = 3'd5;

   // Total bytes on the wire for an image of n words (header + payload + checksum).
   function automatic int image_bytes(input int n);
      return HDR_BYTES + BYTES_PER_WORD * n + 1;
   endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// 8->32 little-endian word assembler. The first byte of a word lands in
// bits [7:0]. When the fourth byte arrives the full word is captured and
// word_done pulses for exactly one cycle on the following cycle.
module boot_word_assembler
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_last,
   output logic        word_done,
   output logic [31:0] word_out
);

   localparam int         LANES    = BYTES_PER_WORD - 1;
   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]         byte_cnt_reg;
   logic [8*LANES-1:0] lane_reg;
   logic [LANES-1:0]   lane_en;
   logic               word_done_reg;
   logic [31:0]        word_out_reg;

   // One enable per buffered byte lane; the top lane is never buffered,
   // it goes straight into the completed word together with the others.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_en
         assign lane_en[gi] = byte_valid && (byte_cnt_reg == 2'(gi));
      end
   endgenerate

   assign word_last = byte_valid && (byte_cnt_reg == LAST_IDX);

   // Buffer the low bytes of the word in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_reg <= '0;
      end else if (clr) begin
         lane_reg <= '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i]) begin
               lane_reg[8*i +: 8] <= byte_in;
            end
         end
      end
   end

   // Byte counter, completed-word capture and one-cycle done strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt_reg  <= '0;
         word_done_reg <= 1'b0;
         word_out_reg  <= '0;
      end else if (clr) begin
         byte_cnt_reg  <= '0;
         word_done_reg <= 1'b0;
      end else begin
         word_done_reg <= word_last;
         if (byte_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
         end
         if (word_last) begin
            word_out_reg <= {byte_in, lane_reg};
         end
      end
   end

   assign word_done = word_done_reg;
   assign word_out  = word_out_reg;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives an image over a byte stream, writes each
// little-endian word into instruction memory at byte address 4*i,
// verifies an XOR checksum and then releases the core's PC.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int MAX_WORDS = 128,
   parameter int ADDR_W    = 9
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   output logic              we0,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [31:0]       wr_din0,
   output logic              resetpc,
   output logic              busy,
   output logic              err
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   logic [2:0]        state_reg;
   logic [2:0]        state_next;
   logic [15:0]       n_reg;
   logic [15:0]       word_idx_reg;
   logic [7:0]        csum_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic              resetpc_reg;
   logic              busy_reg;
   logic              err_reg;

   logic              accept;
   logic              data_byte;
   logic              reload_hit;
   logic [15:0]       n_full;
   logic              word_last;
   logic              word_done;
   logic [31:0]       word_out;

   // Bytes are taken only while an image is being framed or checked.
   always_comb begin
      rx_ready = 1'b0;
      case (state_reg)
         HDR_LO, HDR_HI, DATA, CHECK: rx_ready = 1'b1;
         default:                     rx_ready = 1'b0;
      endcase
   end

   assign accept     = rx_valid && rx_ready;
   assign data_byte  = accept && (state_reg == DATA);
   assign reload_hit = reload && ((state_reg == RUN) || (state_reg == ERR));
   assign n_full     = {rx_data, n_reg[7:0]};

   boot_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clr        (reload_hit),
      .byte_valid (data_byte),
      .byte_in    (rx_data),
      .word_last  (word_last),
      .word_done  (word_done),
      .word_out   (word_out)
   );

   // Next-state logic for image framing, verification and release.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HDR_LO: begin
            if (accept) state_next = HDR_HI;
         end
         HDR_HI: begin
            if (accept) begin
               if (n_full > MAX_N)       state_next = ERR;
               else if (n_full == 16'd0) state_next = CHECK;
               else                      state_next = DATA;
            end
         end
         DATA: begin
            if (word_last && (word_idx_reg + 16'd1 == n_reg)) state_next = CHECK;
         end
         CHECK: begin
            if (accept) state_next = (rx_data == csum_reg) ? RUN : ERR;
         end
         RUN, ERR: begin
            if (reload) state_next = HDR_LO;
         end
         default: state_next = HDR_LO;
      endcase
   end

   // State, header, word index, checksum and status registers. Status flags
   // are registered straight from the next state so they change together with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= HDR_LO;
         n_reg        <= '0;
         word_idx_reg <= '0;
         csum_reg     <= '0;
         wr_addr_reg  <= '0;
         resetpc_reg  <= 1'b0;
         busy_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg   <= state_next;
         resetpc_reg <= (state_next == RUN);
         err_reg     <= (state_next == ERR);
         busy_reg    <= (state_next == HDR_HI) || (state_next == DATA) ||
                        (state_next == CHECK);
         if (reload_hit) begin
            n_reg        <= '0;
            word_idx_reg <= '0;
            csum_reg     <= '0;
         end else begin
            if (accept) begin
               csum_reg <= csum_reg ^ rx_data;
            end
            if (accept && (state_reg == HDR_LO)) begin
               n_reg[7:0] <= rx_data;
            end
            if (accept && (state_reg == HDR_HI)) begin
               n_reg[15:8] <= rx_data;
            end
            if (word_last) begin
               word_idx_reg <= word_idx_reg + 16'd1;
               wr_addr_reg  <= {word_idx_reg[ADDR_W-3:0], 2'b00};
            end
         end
      end
   end

   assign we0      = word_done;
   assign wr_addr0 = wr_addr_reg;
   assign wr_din0  = word_out;
   assign resetpc  = resetpc_reg;
   assign busy     = busy_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the boot loader. A small image model builds byte streams
// and the list of memory writes they must produce; a monitor compares every
// write pulse and the ready/status relation each cycle.
module tb_imem_boot_loader;
   import imem_boot_pkg::*;

   localparam int MAXW  = 128;
   localparam int ADDRW = 9;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [7:0]       rx_data = 8'h00;
   logic             rx_valid = 1'b0;
   logic             reload = 1'b0;
   logic             rx_ready;
   logic             we0;
   logic [ADDRW-1:0] wr_addr0;
   logic [31:0]      wr_din0;
   logic             resetpc;
   logic             busy;
   logic             err;

   int checks = 0;
   int failures = 0;

   logic [7:0]       img[$];
   logic [31:0]      wq[$];
   logic [ADDRW-1:0] exp_addr[$];
   logic [31:0]      exp_data[$];
   logic [ADDRW-1:0] obs_addr[$];
   logic [31:0]      obs_data[$];
   logic             prev_we0 = 1'b0;

   imem_boot_loader #(.MAX_WORDS(MAXW), .ADDR_W(ADDRW)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .reload   (reload),
      .we0      (we0),
      .wr_addr0 (wr_addr0),
      .wr_din0  (wr_din0),
      .resetpc  (resetpc),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
      end
   endtask

   // Monitor: every write must match the next expected write, and the loader
   // must accept bytes exactly when it is neither running nor in error.
   always @(negedge clk) begin
      if (!reset) begin
         check("rx_ready_vs_status", {31'b0, rx_ready}, {31'b0, !(resetpc || err)});
         if (we0) begin
            check("we0_single_cycle", {31'b0, prev_we0}, 32'd0);
            obs_addr.push_back(wr_addr0);
            obs_data.push_back(wr_din0);
            if (exp_addr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_we0: addr 0x%0h data 0x%0h, no write expected", wr_addr0, wr_din0);
            end else begin
               check("wr_addr0", {23'b0, wr_addr0}, {23'b0, exp_addr.pop_front()});
               check("wr_din0", wr_din0, exp_data.pop_front());
            end
            $display("write addr=%0d data=0x%08h", wr_addr0, wr_din0);
         end
         prev_we0 = we0;
      end else begin
         prev_we0 = 1'b0;
      end
   end

   // Image model: header, words (LSB first), XOR checksum; records the writes
   // the image must cause. Oversized counts produce only the header.
   task automatic make_image(input int n, input bit bad);
      logic [7:0]  cs;
      logic [31:0] w;
      img.delete();
      img.push_back(n[7:0]);
      img.push_back(n[15:8]);
      if (n > MAXW) return;
      for (int i = 0; i < n; i++) begin
         w = (i < wq.size()) ? wq[i] : $urandom;
         for (int b = 0; b < 4; b++) img.push_back(w[8*b +: 8]);
         exp_addr.push_back(ADDRW'((4 * i) % (1 << ADDRW)));
         exp_data.push_back(w);
      end
      cs = 8'h00;
      foreach (img[k]) cs = cs ^ img[k];
      img.push_back(bad ? (cs ^ 8'h01) : cs);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit accepted = 1'b0;
      rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      for (int t = 0; t < 20 && !accepted; t++) begin
         @(negedge clk);
         if (rx_ready) accepted = 1'b1;
         @(posedge clk);
         #1;
      end
      rx_valid = 1'b0;
      check("rx_byte_accepted", {31'b0, accepted}, 32'd1);
   endtask

   task automatic send_range(input int first, input int count, input int maxgap);
      for (int k = first; k < first + count; k++) begin
         send_byte(img[k], $urandom_range(maxgap, 0));
      end
   endtask

   task automatic expect_status(input string tag, input bit rp, input bit er, input bit by, input bit rr);
      check({tag, "_resetpc"}, {31'b0, resetpc}, {31'b0, rp});
      check({tag, "_err"}, {31'b0, err}, {31'b0, er});
      check({tag, "_busy"}, {31'b0, busy}, {31'b0, by});
      check({tag, "_rx_ready"}, {31'b0, rx_ready}, {31'b0, rr});
   endtask

   task automatic start_test();
      obs_addr.delete();
      obs_data.delete();
   endtask

   task automatic end_test(input string tag, input int nwrites);
      check({tag, "_writes_pending"}, exp_addr.size(), 32'd0);
      check({tag, "_write_count"}, obs_addr.size(), nwrites);
      exp_addr.delete();
      exp_data.delete();
      $display("test %s done: writes=%0d resetpc=%0b err=%0b", tag, obs_addr.size(), resetpc, err);
   endtask

   task automatic do_reload(input string tag);
      @(posedge clk);
      #1 reload = 1'b1;
      @(posedge clk);
      #1 reload = 1'b0;
      expect_status({tag, "_reload"}, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic pin_small_image(input string tag);
      if (obs_addr.size() == 2) begin
         check({tag, "_w0_addr"}, {23'b0, obs_addr[0]}, 32'd0);
         check({tag, "_w0_data"}, obs_data[0], 32'h00500093);
         check({tag, "_w1_addr"}, {23'b0, obs_addr[1]}, 32'd4);
         check({tag, "_w1_data"}, obs_data[1], 32'h00A00113);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values while reset is held.
      repeat (3) @(posedge clk);
      #1;
      check("rst_we0", {31'b0, we0}, 32'd0);
      check("rst_wr_addr0", {23'b0, wr_addr0}, 32'd0);
      check("rst_wr_din0", wr_din0, 32'd0);
      expect_status("rst", 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Two-word image, one byte per cycle; known checksum 0x73.
      start_test();
      wq = '{32'h00500093, 32'h00A00113};
      make_image(2, 1'b0);
      check("t1_csum_byte_sent", {24'b0, img[10]}, 32'h73);
      send_range(0, 1, 0);
      check("t1_busy_after_first", {31'b0, busy}, 32'd1);
      send_range(1, img.size() - 2, 0);
      check("t1_resetpc_before_csum", {31'b0, resetpc}, 32'd0);
      send_range(img.size() - 1, 1, 0);
      expect_status("t1", 1'b1, 1'b0, 1'b0, 1'b0);
      end_test("t1", 2);
      pin_small_image("t1");
      do_reload("t1");

      // Same image with random valid gaps.
      start_test();
      make_image(2, 1'b0);
      send_range(0, img.size(), 5);
      expect_status("t2", 1'b1, 1'b0, 1'b0, 1'b0);
      end_test("t2", 2);
      pin_small_image("t2");
      do_reload("t2");

      // Corrupted checksum: writes still happen, then error.
      start_test();
      make_image(2, 1'b1);
      send_range(0, img.size(), 0);
      expect_status("t3", 1'b0, 1'b1, 1'b0, 1'b0);
      end_test("t3", 2);
      do_reload("t3");

      // Oversized header: error right after N_hi, no writes.
      start_test();
      make_image(MAXW + 1, 1'b0);
      send_range(0, 2, 0);
      expect_status("t4", 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      end_test("t4", 0);
      do_reload("t4");

      // Empty image: header 0, checksum 0.
      start_test();
      wq.delete();
      make_image(0, 1'b0);
      check("t5_csum_byte_sent", {24'b0, img[2]}, 32'h00);
      send_range(0, img.size(), 0);
      expect_status("t5", 1'b1, 1'b0, 1'b0, 1'b0);
      end_test("t5", 0);
      do_reload("t5");

      // Full-depth image: last write lands at byte address 508.
      start_test();
      make_image(MAXW, 1'b0);
      send_range(0, img.size(), 0);
      expect_status("t6", 1'b1, 1'b0, 1'b0, 1'b0);
      end_test("t6", MAXW);
      if (obs_addr.size() == MAXW) begin
         check("t6_last_addr", {23'b0, obs_addr[MAXW-1]}, 32'd508);
      end
      do_reload("t6");

      // Reset after 5 payload bytes of a 3-word image: only the addr-0 write.
      start_test();
      make_image(3, 1'b0);
      while (exp_addr.size() > 1) begin
         void'(exp_addr.pop_back());
         void'(exp_data.pop_back());
      end
      send_range(0, 2 + 5, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("t7_rst_we0", {31'b0, we0}, 32'd0);
      check("t7_rst_wr_addr0", {23'b0, wr_addr0}, 32'd0);
      check("t7_rst_wr_din0", wr_din0, 32'd0);
      expect_status("t7_rst", 1'b0, 1'b0, 1'b0, 1'b1);
      end_test("t7", 1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;

      // Fresh single-word image after reset, then reload from RUN.
      start_test();
      wq = '{32'hDEADBEEF};
      make_image(1, 1'b0);
      send_range(0, img.size(), 0);
      expect_status("t8", 1'b1, 1'b0, 1'b0, 1'b0);
      end_test("t8", 1);
      if (obs_addr.size() == 1) begin
         check("t8_w0_addr", {23'b0, obs_addr[0]}, 32'd0);
         check("t8_w0_data", obs_data[0], 32'hDEADBEEF);
      end
      do_reload("t8");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
